// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Pipeline boundary register with a valid/ready handshake. It carries a
//   datapath payload and a control payload between two pipeline stages. It
//   supports downstream stalls (out_ready low) and branch/jump kills (flush).
//   The control payload is always zero while no beat is presented, so a
//   bubble can never carry a stray write enable into the next stage.
//
//   SKID = 1 : two storage entries (main + skid). in_ready is registered, so
//              the upstream stage never sees a combinational path from
//              out_ready.
//   SKID = 0 : one storage entry. in_ready is combinational
//              (!out_valid || out_ready).
//
// Parameters:
//   DATA_W    width of the datapath payload
//   CTRL_W    width of the control payload
//   SKID      1 = two-entry skid buffer, 0 = single entry
//
// Ports:
//   clk        in   1        clock, all state changes on the rising edge
//   rst_n      in   1        synchronous active-low reset
//   in_valid   in   1        upstream beat valid
//   in_ready   out  1        stage can accept a beat
//   in_data    in   DATA_W   upstream datapath payload
//   in_ctrl    in   CTRL_W   upstream control payload
//   flush      in   1        synchronous kill of held and incoming beats
//   out_valid  out  1        beat available to downstream
//   out_ready  in   1        downstream accepts (low = stall)
//   out_data   out  DATA_W   datapath payload
//   out_ctrl   out  CTRL_W   control payload, zero whenever out_valid = 0
//   occupancy  out  2        number of held beats (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Number of held beats: EMPTY holds none, ONE holds the main entry,
    // TWO holds main plus skid (reachable only when SKID = 1).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              out_valid_q;
    logic              in_ready_q;
    logic [1:0]        occupancy_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              accept;
    logic              issue;

    // With the skid buffer the ready flag comes straight from a flop; without
    // it, a full stage can only take a new beat when the held one leaves in
    // the same cycle.
    assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);

    assign accept = in_valid && in_ready;
    assign issue  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = occupancy_q;

    // Next-state decode. TWO is only entered when a beat arrives while the
    // held one stalls; with SKID = 0 in_ready is low in that situation, so
    // the single-entry variant never gets there. Flush overrides everything
    // except reset, which is handled in the register block.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !issue) begin
                    state_next = TWO;
                end else if (!accept && issue) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (issue) begin
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (flush) begin
            state_next = EMPTY;
        end
    end

    // State and payload registers. The main entry always drives the outputs;
    // the skid entry holds the beat that arrived while main was stalled, and
    // moves into main on the next issue, which keeps the stream in FIFO
    // order. Every path into EMPTY zeroes the control payload so a bubble
    // never carries live enables; the data payload is left as is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
            main_data   <= '0;
            main_ctrl   <= '0;
            skid_data   <= '0;
            skid_ctrl   <= '0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next != EMPTY);
            in_ready_q  <= (state_next != TWO);
            case (state_next)
                ONE:     occupancy_q <= 2'd1;
                TWO:     occupancy_q <= 2'd2;
                default: occupancy_q <= 2'd0;
            endcase

            if (flush) begin
                main_ctrl <= '0;
                skid_data <= '0;
                skid_ctrl <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end
                    end
                    ONE: begin
                        if (accept && issue) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else if (accept) begin
                            if (SKID) begin
                                skid_data <= in_data;
                                skid_ctrl <= in_ctrl;
                            end
                        end else if (issue) begin
                            main_ctrl <= '0;
                        end
                    end
                    TWO: begin
                        if (issue) begin
                            main_data <= skid_data;
                            main_ctrl <= skid_ctrl;
                        end
                    end
                    default: begin
                        main_ctrl <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. It is the next-generation replacement for the fixed ID/EX-style boundary registers. Every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own payload widths. Stalls come from downstream backpressure and branch/jump kills come from `flush`. Control fields are guaranteed zero on any bubble, so no stray register or memory write enable can leak.

## Interface
- `DATA_W`, 32, width of datapath payload (pc, operands, imm, reg indices packed by the instantiating stage).
- `CTRL_W`, 16, width of control payload (write enables, ALU op, result select…). Forced to zero on bubbles.
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  DATA_W  upstream datapath payload.
- `in_ctrl`  in  CTRL_W  upstream control payload.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `out_valid`  out  1  beat available to downstream.
- `out_ready`  in  1  downstream accepts (low = stall).
- `out_data`  out  DATA_W  datapath payload.
- `out_ctrl`  out  CTRL_W  control payload; zero whenever `out_valid`=0.
- `occupancy`  out  2  held beats (0..2; max 1 when SKID=0).

## Operation
- Accept = `in_valid && in_ready`; issue = `out_valid && out_ready`. Payload moves only on these events; no beat is duplicated or lost except by `flush`.
- Storage: main register (drives outputs), plus skid register when SKID=1.
- SKID=1 states:
  - EMPTY: accept → ONE.
  - ONE: accept & issue → ONE (main ← in); accept & !issue → TWO (skid ← in); !accept & issue → EMPTY; else hold.
  - TWO: issue → ONE (main ← skid); else hold.
  - `in_ready` = registered (next_state != TWO), so it never depends combinationally on `out_ready`.
- SKID=0: states EMPTY/ONE only. `in_ready` = !out_valid | out_ready (combinational). Accept & issue in the same cycle → main ← in.
- Ordering is FIFO: the skid beat always issues before any later beat.
- Bubble rule: on any transition into EMPTY, `out_ctrl` ← 0. `out_data` holds its last value (don't-care, not checked).
- `flush` (priority below reset, above everything else):
  - next state EMPTY, `out_valid`=0, skid cleared, `out_ctrl`=0.
  - A beat presented in the flush cycle is accepted if `in_ready`=1 and discarded.
  - An issue in the flush cycle still counts downstream; the stage does not retract it.
- `occupancy` = 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Reset (`rst_n`=0 at clock edge): state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid contents 0, `occupancy`=0.
- `in_ready`: 1 during reset when SKID=1 (EMPTY), and 1 when SKID=0.
- Deassertion mid-operation discards all held beats. No partial state survives.
- Latency: beat accepted at edge N is on `out_*` after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained with `out_ready`=1 in both modes.
- SKID=1 backpressure: with `out_ready` dropping at cycle N, at most one extra beat is absorbed (TWO). `in_ready` is low from cycle N+1 until the cycle after the first issue.
- Flush effect is visible the cycle after `flush`=1. `in_ready` after flush is 1.
- Simultaneous `flush` & `rst_n`=0: reset wins (identical result).
- Outputs are register-driven except `in_ready` when SKID=0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1, `in_ctrl`=16'hFFFF → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0. First accept after release appears 1 cycle later.
- Streaming: SKID=1, `out_ready`=1, feed data 1..100 back-to-back → outputs 1..100 in order, one per cycle, 1-cycle latency, `in_ready` constantly 1.
- Backpressure: SKID=1, stream 1,2,3…, drop `out_ready` for 4 cycles → `occupancy` reaches 2 and `in_ready`=0 within 1 cycle. On release the output order is 1,2,3… with no gap/duplicate. Repeat with SKID=0: `in_ready` follows `out_ready` combinationally when full.
- Flush in TWO: fill to 2 beats (ctrl 16'h0001, 16'h0002), assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0. The flush-cycle input never appears.
- Bubble control: accept one beat with ctrl 16'hBEEF, then `in_valid`=0 and `out_ready`=1 → after issue, `out_valid`=0 and `out_ctrl`=0.
- Random: random `in_valid`/`out_ready`/sparse `flush` for 10k cycles, both SKID values. Scoreboard checks order, no loss except flush-killed beats, and `out_ctrl`=0 whenever `out_valid`=0.
